// File: rtl/modexp_ctrl_if.sv
// Start/done handshake between the exponentiation sequencer (master) and a
// Montgomery multiplier (slave).
interface modexp_ctrl_if #(
   parameter int WIDTH = 1024
);
   // Handshake: master raises mm_start for exactly one cycle with mm_a/mm_b/mm_m
   // valid and holds them until the slave answers with a one-cycle mm_done,
   // during which mm_result is valid; there is never more than one op in flight.
   logic             mm_start;
   logic [WIDTH-1:0] mm_a;
   logic [WIDTH-1:0] mm_b;
   logic [WIDTH-1:0] mm_m;
   logic [WIDTH-1:0] mm_result;
   logic             mm_done;

   modport master (
      output mm_start, mm_a, mm_b, mm_m,
      input  mm_result, mm_done
   );

   modport slave (
      input  mm_start, mm_a, mm_b, mm_m,
      output mm_result, mm_done
   );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer computing X^E mod M in the
// Montgomery domain by driving an external multiplier one op at a time.
module modexp_ctrl #(
   parameter int WIDTH  = 1024,
   parameter int ELEN_W = 11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WIDTH-1:0]  in_x,
   input  logic [WIDTH-1:0]  in_e,
   input  logic [ELEN_W-1:0] in_elen,
   input  logic [WIDTH-1:0]  in_m,
   input  logic [WIDTH-1:0]  in_r,
   input  logic [WIDTH-1:0]  in_r2,
   modexp_ctrl_if.master     mm,
   output logic [WIDTH-1:0]  result,
   output logic              done,
   output logic              busy,
   output logic [3:0]        dbg_state_o
);

   localparam int IDX_W = $clog2(WIDTH);

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_CONV    = 4'd1,
      S_CONV_W  = 4'd2,
      S_SQ      = 4'd3,
      S_SQ_W    = 4'd4,
      S_MUL     = 4'd5,
      S_MUL_W   = 4'd6,
      S_FINAL   = 4'd7,
      S_FINAL_W = 4'd8,
      S_DONE    = 4'd9
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] e_q, m_q, acc_q, xt_q, result_q;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] acc_next;
   logic             e_bit;
   logic             idx_zero;

   assign e_bit    = e_q[idx_q];
   assign idx_zero = (idx_q == '0);

   // Accumulator value as it will be after this edge, so the next op's
   // operands can be registered on the same edge the previous result lands.
   always_comb begin
      acc_next = acc_q;
      if ((state_q == S_SQ_W || state_q == S_MUL_W) && mm.mm_done) begin
         acc_next = mm.mm_result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = (in_elen != '0) ? S_CONV : S_FINAL;
         S_CONV:    state_d = S_CONV_W;
         S_SQ:      state_d = S_SQ_W;
         S_MUL:     state_d = S_MUL_W;
         S_FINAL:   state_d = S_FINAL_W;
         S_CONV_W:  if (mm.mm_done) state_d = S_SQ;
         S_SQ_W: begin
            if (mm.mm_done) begin
               if (e_bit)         state_d = S_MUL;
               else if (idx_zero) state_d = S_FINAL;
               else               state_d = S_SQ;
            end
         end
         S_MUL_W:   if (mm.mm_done) state_d = idx_zero ? S_FINAL : S_SQ;
         S_FINAL_W: if (mm.mm_done) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Operands are loaded on the edge entering an op state and then held
   // untouched through that op's wait sub-state.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      unique case (state_d)
         S_CONV: if (state_q != S_CONV) begin
            a_d = in_x;
            b_d = in_r2;
         end
         S_SQ: if (state_q != S_SQ) begin
            a_d = acc_next;
            b_d = acc_next;
         end
         S_MUL: if (state_q != S_MUL) begin
            a_d = acc_next;
            b_d = xt_q;
         end
         S_FINAL: if (state_q != S_FINAL) begin
            a_d = (state_q == S_IDLE) ? in_r : acc_next;
            b_d = WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q      <= '0;
         m_q      <= '0;
         acc_q    <= '0;
         xt_q     <= '0;
         result_q <= '0;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_next;
         unique case (state_q)
            S_IDLE: if (start) begin
               e_q   <= in_e;
               m_q   <= in_m;
               acc_q <= in_r;
               idx_q <= IDX_W'(in_elen - ELEN_W'(1));
            end
            S_CONV_W: if (mm.mm_done) xt_q <= mm.mm_result;
            S_SQ_W: if (mm.mm_done && !e_bit && !idx_zero) idx_q <= idx_q - 1'b1;
            S_MUL_W: if (mm.mm_done && !idx_zero) idx_q <= idx_q - 1'b1;
            S_FINAL_W: if (mm.mm_done) result_q <= mm.mm_result;
            default: ;
         endcase
      end
   end

   always_comb begin
      mm.mm_start = (state_q == S_CONV) || (state_q == S_SQ) ||
                    (state_q == S_MUL)  || (state_q == S_FINAL);
      mm.mm_a     = a_q;
      mm.mm_b     = b_q;
      mm.mm_m     = m_q;
      done        = (state_q == S_DONE);
      busy        = (state_q != S_IDLE);
      result      = result_q;
      dbg_state_o = state_q;
   end

endmodule
